// File: rtl/bounded_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : bounded_counter_bank_if
// Purpose  : Control/status bundle for the bounded counter bank.
// Revision : 1.0
// ============================================================================
interface bounded_counter_bank_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 3
);
    logic [NCH-1:0]       inc;
    logic [NCH-1:0]       dec;
    logic [NCH-1:0]       wrap_mode;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] load_val;
    logic                 clr_flags;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       at_max;
    logic [NCH-1:0]       at_zero;
    logic [NCH-1:0]       limit_hit;

    modport master (
        output inc, dec, wrap_mode, load, load_val, clr_flags,
        input  count, at_max, at_zero, limit_hit
    );

    modport slave (
        input  inc, dec, wrap_mode, load, load_val, clr_flags,
        output count, at_max, at_zero, limit_hit
    );
endinterface
`default_nettype wire

// File: rtl/bounded_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : bounded_counter_bank
// Purpose  : NCH independent up/down counters bounded to 0..MAX_VAL with
//            saturate/wrap modes, parallel load and sticky limit flags.
// Revision : 1.0
// ============================================================================
module bounded_counter_bank #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = 3
) (
    input wire                     clk,
    input wire                     resetn,
    bounded_counter_bank_if.slave  bus
);

    localparam logic [WIDTH:0] c_max  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] c_one  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_zero = '0;

    logic [NCH-1:0][WIDTH-1:0] r_count;
    logic [NCH-1:0]            r_at_max;
    logic [NCH-1:0]            r_at_zero;
    logic [NCH-1:0]            r_hit;

    logic [NCH-1:0][WIDTH:0]   w_nxt;
    logic [NCH-1:0]            w_set;

    // Returns {bound_event, next_count}; one extra bit keeps MAX_VAL == 2^WIDTH-1 safe.
    function automatic logic [WIDTH+1:0] f_step(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             do_ld,
        input logic             do_inc,
        input logic             do_dec,
        input logic             wrap
    );
        logic [WIDTH:0] v_cur;
        logic [WIDTH:0] v_ld;
        logic [WIDTH:0] v_nxt;
        logic           v_set;
        v_cur = {1'b0, cur};
        v_ld  = {1'b0, ld};
        v_nxt = v_cur;
        v_set = 1'b0;
        if (do_ld) begin
            if (v_ld > c_max) begin
                v_nxt = c_max;
                v_set = 1'b1;
            end else begin
                v_nxt = v_ld;
            end
        end else if (do_inc && !do_dec) begin
            if (v_cur >= c_max) begin
                v_nxt = wrap ? c_zero : c_max;
                v_set = 1'b1;
            end else begin
                v_nxt = v_cur + c_one;
            end
        end else if (do_dec && !do_inc) begin
            if (v_cur == c_zero) begin
                v_nxt = wrap ? c_max : c_zero;
                v_set = 1'b1;
            end else begin
                v_nxt = v_cur - c_one;
            end
        end
        return {v_set, v_nxt};
    endfunction

    always_comb begin
        w_nxt = '0;
        w_set = '0;
        for (int i = 0; i < NCH; i++) begin
            {w_set[i], w_nxt[i]} = f_step(r_count[i],
                                          bus.load_val[i*WIDTH +: WIDTH],
                                          bus.load[i], bus.inc[i],
                                          bus.dec[i], bus.wrap_mode[i]);
        end
    end

    // Flags are derived from the next value so they line up with count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_at_max  <= '0;
            r_at_zero <= '1;
            r_hit     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_count[i]   <= w_nxt[i][WIDTH-1:0];
                r_at_max[i]  <= (w_nxt[i] == c_max);
                r_at_zero[i] <= (w_nxt[i] == c_zero);
            end
            r_hit <= w_set | (r_hit & ~{NCH{bus.clr_flags}});
        end
    end

    assign bus.count     = r_count;
    assign bus.at_max    = r_at_max;
    assign bus.at_zero   = r_at_zero;
    assign bus.limit_hit = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_bounded_counter_bank.sv
`default_nettype none
// Bench for bounded_counter_bank: directed literal checks plus a per-cycle
// comparison against an integer model of the counting rules.
module tb_bounded_counter_bank;

    localparam int NCH     = 4;
    localparam int WIDTH   = 3;
    localparam int MAX_VAL = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bounded_counter_bank_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    bounded_counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_count [NCH] = '{default: 0};
    bit m_hit   [NCH] = '{default: 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Integer model of the counting rules
    always @(posedge clk or negedge resetn) begin
        int lv;
        bit ev;
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                m_count[i] = 0;
                m_hit[i]   = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                lv = int'(bus.load_val[i*WIDTH +: WIDTH]);
                ev = 0;
                if (bus.load[i]) begin
                    if (lv > MAX_VAL) begin
                        m_count[i] = MAX_VAL;
                        ev = 1;
                    end else begin
                        m_count[i] = lv;
                    end
                end else if (bus.inc[i] && !bus.dec[i]) begin
                    if (m_count[i] == MAX_VAL) begin
                        ev = 1;
                        m_count[i] = bus.wrap_mode[i] ? 0 : MAX_VAL;
                    end else begin
                        m_count[i] = m_count[i] + 1;
                    end
                end else if (bus.dec[i] && !bus.inc[i]) begin
                    if (m_count[i] == 0) begin
                        ev = 1;
                        m_count[i] = bus.wrap_mode[i] ? MAX_VAL : 0;
                    end else begin
                        m_count[i] = m_count[i] - 1;
                    end
                end
                m_hit[i] = ev || (m_hit[i] && !bus.clr_flags);
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH*WIDTH-1:0] ec;
        logic [NCH-1:0]       emax, ezero, ehit, dmax, dzero;
        logic                 over;
        int                   dc;
        if (resetn) begin
            over = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ec[i*WIDTH +: WIDTH] = WIDTH'(m_count[i]);
                emax[i]  = (m_count[i] == MAX_VAL);
                ezero[i] = (m_count[i] == 0);
                ehit[i]  = m_hit[i];
                dc       = int'(bus.count[i*WIDTH +: WIDTH]);
                if (dc > MAX_VAL) over = 1'b1;
                dmax[i]  = (dc == MAX_VAL);
                dzero[i] = (dc == 0);
            end
            chk("model_count", 32'(bus.count), 32'(ec));
            chk("model_at_max", 32'(bus.at_max), 32'(emax));
            chk("model_at_zero", 32'(bus.at_zero), 32'(ezero));
            chk("model_limit_hit", 32'(bus.limit_hit), 32'(ehit));
            chk("count_le_max", 32'(over), 32'(0));
            chk("flags_vs_count", 32'({bus.at_max, bus.at_zero}), 32'({dmax, dzero}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e_c0 [5] = '{1, 2, 3, 3, 3};
        int e_m0 [5] = '{0, 0, 1, 1, 1};
        int e_h0 [5] = '{0, 0, 0, 1, 1};
        int e_c1 [4] = '{1, 2, 3, 0};
        int e_h1 [4] = '{0, 0, 0, 1};

        bus.inc = '0; bus.dec = '0; bus.wrap_mode = '0; bus.load = '0;
        bus.load_val = '0; bus.clr_flags = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'(0));
        chk("rst_at_zero", 32'(bus.at_zero), 32'hF);
        chk("rst_at_max", 32'(bus.at_max), 32'(0));
        chk("rst_limit_hit", 32'(bus.limit_hit), 32'(0));
        @(negedge clk); #2 resetn = 1'b1;
        tick();

        // ch0 saturating increments
        bus.inc = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sat_count0", 32'(bus.count[2:0]), 32'(e_c0[k]));
            chk("sat_at_max0", 32'(bus.at_max[0]), 32'(e_m0[k]));
            chk("sat_hit0", 32'(bus.limit_hit[0]), 32'(e_h0[k]));
            chk("others_zero", 32'(bus.count[11:3]), 32'(0));
            chk("others_at_zero", 32'(bus.at_zero[3:1]), 32'(3'b111));
        end
        bus.inc = '0;

        // ch1 wrapping increments, then wrapping decrement
        bus.wrap_mode = 4'b0010;
        bus.inc = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap_count1", 32'(bus.count[5:3]), 32'(e_c1[k]));
            chk("wrap_hit1", 32'(bus.limit_hit[1]), 32'(e_h1[k]));
        end
        bus.inc = '0;
        bus.dec = 4'b0010;
        tick();
        chk("wrap_dec_count1", 32'(bus.count[5:3]), 32'(3));
        chk("wrap_dec_at_max1", 32'(bus.at_max[1]), 32'(1));
        bus.dec = '0;

        // ch2 clamped load, then load beats inc
        bus.load = 4'b0100;
        bus.load_val = 12'o0700;
        tick();
        chk("load_clamp_count2", 32'(bus.count[8:6]), 32'(3));
        chk("load_clamp_hit2", 32'(bus.limit_hit[2]), 32'(1));
        bus.load_val = 12'o0200;
        bus.inc = 4'b0100;
        tick();
        chk("load_wins_count2", 32'(bus.count[8:6]), 32'(2));
        bus.load = '0; bus.inc = '0; bus.load_val = '0;

        // ch3 inc+dec holds; clr_flags loses to a same-cycle set
        bus.inc = 4'b1000;
        tick();
        chk("ch3_up", 32'(bus.count[11:9]), 32'(1));
        bus.dec = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("incdec_hold3", 32'(bus.count[11:9]), 32'(1));
            chk("incdec_noflag3", 32'(bus.limit_hit[3]), 32'(0));
        end
        bus.inc = '0;
        tick();
        chk("ch3_down", 32'(bus.count[11:9]), 32'(0));
        chk("ch3_at_zero", 32'(bus.at_zero[3]), 32'(1));
        bus.clr_flags = 1'b1;
        tick();
        chk("clr_vs_set_count3", 32'(bus.count[11:9]), 32'(0));
        chk("clr_vs_set_hits", 32'(bus.limit_hit), 32'(4'b1000));
        chk("all_counts", 32'(bus.count), 32'(12'o0233));
        bus.clr_flags = 1'b0; bus.dec = '0;

        // Asynchronous reset between clock edges
        bus.inc = 4'b0100;
        tick();
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.count), 32'(0));
        chk("async_rst_at_zero", 32'(bus.at_zero), 32'hF);
        chk("async_rst_at_max", 32'(bus.at_max), 32'(0));
        chk("async_rst_hit", 32'(bus.limit_hit), 32'(0));
        bus.inc = '0;
        @(negedge clk); #2 resetn = 1'b1;
        tick();

        // Random traffic, checked every cycle by the compare process
        for (int k = 0; k < 10000; k++) begin
            bus.inc       = 4'($urandom);
            bus.dec       = 4'($urandom);
            bus.wrap_mode = 4'($urandom);
            bus.load      = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus.load_val  = 12'($urandom);
            bus.clr_flags = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.inc = '0; bus.dec = '0; bus.load = '0; bus.clr_flags = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bounded_counter_bank.md
Name: bounded_counter_bank

Overview:
Bank of NCH independent up/down counters, each bounded to the range 0..MAX_VAL, with per-channel saturate or wrap mode, parallel load and sticky limit flags. Generalises the fixed 0..3 counter into a reusable block for event and credit counting across the design. Core invariant: no channel ever holds a value above MAX_VAL under any input sequence, including load and reset release.

Parameters:
NCH, 4, number of independent counter channels (>=1)
WIDTH, 3, bits per counter
MAX_VAL, 3, inclusive upper bound; legal range 1 <= MAX_VAL <= 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
resetn  input  1  reset; asynchronous, active-low
inc  input  NCH  per-channel increment request
dec  input  NCH  per-channel decrement request
wrap_mode  input  NCH  per-channel mode: 0 = saturate, 1 = wrap
load  input  NCH  per-channel parallel load strobe
load_val  input  NCH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH]
clr_flags  input  1  clears all limit_hit bits
count  output  NCH*WIDTH  registered counter values, packed the same way as load_val
at_max  output  NCH  registered; 1 when the channel count == MAX_VAL
at_zero  output  NCH  registered; 1 when the channel count == 0
limit_hit  output  NCH  sticky; set when a bound is reached or a load is clamped

Behaviour:
- Reset (asynchronous assert, release synchronised by the system): count = 0 for all channels, at_zero = all 1s, at_max = all 0s, limit_hit = all 0s. Asserting reset mid-operation aborts all activity immediately.
- All outputs are registered. An action sampled on edge N is visible after edge N; latency is 1 cycle. at_max and at_zero always agree with count in the same cycle.
- Per-channel priority, evaluated each clock edge:
  1. load
  2. inc XOR dec
  3. hold
- inc and dec asserted together with no load: count holds and no flag is set.
- Load: next count = min(load_val_i, MAX_VAL). If load_val_i > MAX_VAL, the count clamps to MAX_VAL and limit_hit_i is set. inc and dec are ignored in a load cycle.
- inc when count < MAX_VAL: count + 1.
- inc when count == MAX_VAL:
  - saturate mode: count holds at MAX_VAL and limit_hit_i is set.
  - wrap mode: count goes to 0 and limit_hit_i is set.
- dec when count > 0: count - 1.
- dec when count == 0:
  - saturate mode: count holds at 0 and limit_hit_i is set.
  - wrap mode: count goes to MAX_VAL and limit_hit_i is set.
- wrap_mode is sampled each cycle; a mode change takes effect on the next bound event, and the count is never altered by the mode change itself.
- limit_hit: clr_flags clears all bits on the next edge. If clr_flags coincides with a set event on channel i, the set wins for channel i.
- Counter arithmetic is done at WIDTH+1 bits, so no intermediate overflow occurs when MAX_VAL == 2^WIDTH-1.
- Channels are fully independent; one channel's activity never affects another.
- There are no other state, modes or hidden encodings. All input combinations are defined above.

Test Plan:
- Reset release, then 5 inc pulses on ch0 in saturate mode -> count0 goes 1,2,3,3,3; at_max0 = 1 from the 3rd edge; limit_hit0 set on the 4th edge; other channels stay 0 with at_zero = 1.
- ch1 in wrap mode: 4 inc pulses -> 1,2,3,0, limit_hit1 set on the 4th. Then 1 dec -> count1 = 3, at_max1 = 1.
- ch2 load_val = 7 with MAX_VAL = 3 -> count2 = 3, limit_hit2 = 1. load_val = 2 with inc = 1 in the same cycle -> count2 = 2 (load wins).
- ch3 inc and dec together for 3 cycles from count 1 -> holds at 1, no flag. Then clr_flags together with a saturating dec at 0 -> limit_hit3 stays 1 and all other limit_hit bits clear.
- Assert resetn low asynchronously mid-count, away from a clock edge -> all counts 0, at_zero all 1s, limit_hit 0, without waiting for a clock edge.
- Random inc/dec/load/mode stimulus for 10k cycles -> count_i <= MAX_VAL every cycle, and at_max/at_zero are consistent with count every cycle.
